// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file write-port owner merging ALU results with queued loads
//
// Purpose:
//   Sole driver of the register-file write port (A3/wE3/wD3). Live ALU
//   results always take the port on the next edge. Load results are
//   buffered in a small circular FIFO and drain on cycles with no live
//   ALU write. Writes addressed to r0 never reach the port.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   alu_valid, alu_rd, alu_data      single-cycle ALU result
//   mem_valid, mem_ready             load handshake (accept on both high)
//   mem_rd, mem_data                 load destination and data
//   A3, wE3, wD3                     registered register-file write port
//   busy                             per-register "queued load pending"
//   fifo_count                       number of queued loads (0..DEPTH)
//   err_waw                          sticky ALU-over-pending-load flag

module regfile_writeback #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] A3,
  output logic              wE3,
  output logic [DATA_W-1:0] wD3,
  output logic [7:0]        busy,
  output logic [ADDR_W-1:0] fifo_count,
  output logic              err_waw
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [ADDR_W-1:0] rd_mem_d   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] count_q, count_d;

  logic [ADDR_W-1:0] a3_q, a3_d;
  logic              we3_q, we3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              err_waw_q, err_waw_d;

  logic              live_alu, push, pop;
  logic [7:0]        busy_c;
  logic [PTR_W-1:0]  wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];

  // Ready reflects the registered count only, so a full FIFO refuses a
  // load even in a cycle that also pops.
  assign mem_ready = !rst && (count_q < ADDR_W'(DEPTH));
  assign live_alu  = alu_valid && (alu_rd != '0);
  assign push      = mem_valid && mem_ready && (mem_rd != '0);
  assign pop       = !live_alu && (count_q != '0);

  // Per-entry valid bits make busy a pure function of FIFO contents; a
  // popped entry drops out once valid_q clears on the pop edge.
  always_comb begin
    busy_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) busy_c[rd_mem_q[i]] = 1'b1;
    end
    busy_c[0] = 1'b0;
  end

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    valid_d    = valid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    we3_d      = 1'b0;
    err_waw_d  = err_waw_q | (live_alu && busy_c[alu_rd]);

    if (live_alu) begin
      we3_d = 1'b1;
      a3_d  = alu_rd;
      wd3_d = alu_data;
    end else if (pop) begin
      we3_d = 1'b1;
      a3_d  = rd_mem_q[rd_idx];
      wd3_d = data_mem_q[rd_idx];
    end

    // Push needs not-full and pop needs not-empty, so when both happen
    // they always touch different slots.
    if (pop) begin
      valid_d[rd_idx] = 1'b0;
      rd_ptr_d = (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push) begin
      rd_mem_d[wr_idx]   = mem_rd;
      data_mem_d[wr_idx] = mem_data;
      valid_d[wr_idx]    = 1'b1;
      wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
      valid_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      a3_q      <= '0;
      we3_q     <= 1'b0;
      wd3_q     <= '0;
      err_waw_q <= 1'b0;
    end else begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      a3_q       <= a3_d;
      we3_q      <= we3_d;
      wd3_q      <= wd3_d;
      err_waw_q  <= err_waw_d;
    end
  end

  assign A3         = a3_q;
  assign wE3        = we3_q;
  assign wD3        = wd3_q;
  assign busy       = busy_c;
  assign fifo_count = count_q;
  assign err_waw    = err_waw_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed and random scoreboard bench for regfile_writeback
module tb_regfile_writeback;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [18:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_rd;
  logic [18:0] mem_data;
  logic [2:0]  A3;
  logic        wE3;
  logic [18:0] wD3;
  logic [7:0]  busy;
  logic [2:0]  fifo_count;
  logic        err_waw;

  regfile_writeback #(.DATA_W(19), .ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .A3(A3), .wE3(wE3), .wD3(wD3),
    .busy(busy), .fifo_count(fifo_count), .err_waw(err_waw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queued loads, sticky error, expected port state.
  logic [2:0]  m_rd[$];
  logic [18:0] m_dat[$];
  logic        m_err = 1'b0;
  logic        e_we  = 1'b0;
  logic [2:0]  e_a3  = '0;
  logic [18:0] e_wd  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  // One clock: check combinational/state outputs before the edge, advance
  // the model with the driven inputs, then check the write port after it.
  task automatic tick();
    logic [7:0] mb;
    logic live, acc;
    #1;
    mb = '0;
    foreach (m_rd[k]) mb[m_rd[k]] = 1'b1;
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, (!rst && m_rd.size() < 4)});
    chk("fifo_count", {29'd0, fifo_count}, m_rd.size());
    chk("busy", {24'd0, busy}, {24'd0, mb});
    chk("err_waw", {31'd0, err_waw}, {31'd0, m_err});
    if (rst) begin
      m_rd.delete(); m_dat.delete();
      m_err = 1'b0; e_we = 1'b0; e_a3 = '0; e_wd = '0;
    end else begin
      live = alu_valid && (alu_rd != 3'd0);
      acc  = mem_valid && (m_rd.size() < 4);
      if (live && mb[alu_rd]) m_err = 1'b1;
      if (live) begin
        e_we = 1'b1; e_a3 = alu_rd; e_wd = alu_data;
      end else if (m_rd.size() > 0) begin
        e_we = 1'b1; e_a3 = m_rd.pop_front(); e_wd = m_dat.pop_front();
      end else begin
        e_we = 1'b0;
      end
      if (acc && mem_rd != 3'd0) begin
        m_rd.push_back(mem_rd);
        m_dat.push_back(mem_data);
      end
    end
    @(posedge clk);
    #1;
    chk("wE3", {31'd0, wE3}, {31'd0, e_we});
    chk("A3", {29'd0, A3}, {29'd0, e_a3});
    chk("wD3", {13'd0, wD3}, {13'd0, e_wd});
    chk("we_r0", {31'd0, (wE3 && A3 == 3'd0)}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();                      // second reset cycle, checks mem_ready=0
    rst = 1'b0;
    tick();
    chk("rst_we", {31'd0, wE3}, 32'd0);
    chk("rst_a3", {29'd0, A3}, 32'd0);

    // Single ALU write and the idle cycle after it.
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 19'h12345;
    tick();
    chk("tp_alu_we", {31'd0, wE3}, 32'd1);
    chk("tp_alu_a3", {29'd0, A3}, 32'd3);
    chk("tp_alu_wd", {13'd0, wD3}, 32'h12345);
    idle_inputs();
    tick();
    chk("tp_alu_off", {31'd0, wE3}, 32'd0);

    // Single load with ALU idle: minimum latency.
    mem_valid = 1'b1; mem_rd = 3'd5; mem_data = 19'h7FFFF;
    tick();
    idle_inputs();
    #1;
    chk("tp_busy5", {24'd0, busy}, 32'h20);
    chk("tp_cnt1", {29'd0, fifo_count}, 32'd1);
    tick();
    chk("tp_ld_a3", {29'd0, A3}, 32'd5);
    tick();

    // Fill under continuous ALU traffic, refuse a fifth, then drain 1,2,4,6.
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 3'd7; alu_data = 19'(i + 16);
      mem_valid = 1'b1; mem_rd = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : (i == 2) ? 3'd4 : 3'd6;
      mem_data  = 19'(100 + i);
      tick();
    end
    mem_rd = 3'd3; mem_data = 19'h3333;
    tick();
    chk("tp_full_cnt", {29'd0, fifo_count}, 32'd4);
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();

    // r0 traffic is ignored on both paths.
    alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 19'h1111;
    mem_valid = 1'b1; mem_rd = 3'd0; mem_data = 19'h2222;
    tick();
    idle_inputs();
    tick();
    chk("tp_r0_cnt", {29'd0, fifo_count}, 32'd0);

    // WAW: load to r2 queued, ALU to r2 the next cycle.
    mem_valid = 1'b1; mem_rd = 3'd2; mem_data = 19'h0AAAA;
    tick();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 19'h05555;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
    chk("tp_waw_sticky", {31'd0, err_waw}, 32'd1);

    // Three queued loads discarded by a mid-operation reset.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 3'd7; alu_data = 19'(200 + i);
      mem_valid = 1'b1; mem_rd = 3'(i + 1); mem_data = 19'(300 + i);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("tp_rst_cnt", {29'd0, fifo_count}, 32'd0);

    // Eight back-to-back push/pop pairs wrap both pointers twice.
    for (int i = 0; i < 8; i++) begin
      mem_valid = 1'b1; mem_rd = 3'((i % 7) + 1); mem_data = 19'(19'h40000 + i);
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // Random mix, including occasional resets.
    for (int i = 0; i < 80; i++) begin
      rst       = ($urandom_range(0, 24) == 0);
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = 3'($urandom_range(0, 7));
      alu_data  = 19'($urandom);
      mem_valid = ($urandom_range(0, 1) == 0);
      mem_rd    = 3'($urandom_range(0, 7));
      mem_data  = 19'($urandom);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
